cpu_sram_like_bridge: RTL

//  Downstream of the CPU top: takes the per-cycle inst/data SRAM ports the core drives
//  and serialises them onto one shared SRAM-like request/acknowledge bus of variable latency.

---
 rtl/cpu_sram_like_bridge_pkg.sv | 10 +
 rtl/cpu_sram_like_bridge_if.sv | 13 +
 rtl/sram_like_req_port.sv | 50 +++++
 rtl/cpu_sram_like_bridge.sv | 103 ++++++++++
 4 files changed

// File: rtl/cpu_sram_like_bridge_pkg.sv
// cpu_sram_like_bridge_pkg: shared FSM states, bus size codes and strobe decoding
package cpu_sram_like_bridge_pkg;
  typedef enum logic [2:0] {IDLE, FIRST_REQ, FIRST_WAIT, SECOND_REQ, SECOND_WAIT, RELEASE} state_e;
  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  function automatic logic [1:0] wen_to_size(input logic [3:0] wen);
    return (wen == 4'b0011 || wen == 4'b1100) ? SZ_H : $onehot(wen) ? SZ_B : SZ_W;
  endfunction
endpackage

// File: rtl/cpu_sram_like_bridge_if.sv
// cpu_sram_like_bridge_if: shared SRAM-like request/acknowledge bus
interface cpu_sram_like_bridge_if #(parameter int ADDR_W = 32);
  logic              mem_req;
  logic              mem_wr;
  logic [1:0]        mem_size;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_addr_ok;
  logic              mem_data_ok;
  logic [31:0]       mem_rdata;
  modport master(output mem_req, mem_wr, mem_size, mem_addr, mem_wdata, input mem_addr_ok, mem_data_ok, mem_rdata);
  modport slave(input mem_req, mem_wr, mem_size, mem_addr, mem_wdata, output mem_addr_ok, mem_data_ok, mem_rdata);
endinterface

// File: rtl/sram_like_req_port.sv
// sram_like_req_port: holds one access payload and runs its request/wait handshake
module sram_like_req_port
  import cpu_sram_like_bridge_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              load,
  input  logic              ld_wr,
  input  logic [1:0]        ld_size,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [31:0]       ld_wdata,
  input  logic              in_req,
  input  logic              in_wait,
  output logic              accepted,
  output logic              done,
  cpu_sram_like_bridge_if.master bus
);
  logic              wr_q, wr_d;
  logic [1:0]        size_q, size_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  always_comb begin
    wr_d     = load ? ld_wr : wr_q;
    size_d   = load ? ld_size : size_q;
    addr_d   = load ? ld_addr : addr_q;
    wdata_d  = load ? ld_wdata : wdata_q;
    accepted = in_req && bus.mem_addr_ok;
    done     = (accepted || in_wait) && bus.mem_data_ok;
  end
  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_q    <= 1'b0;
      size_q  <= SZ_W;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      wr_q    <= wr_d;
      size_q  <= size_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end
  assign bus.mem_req   = in_req;
  assign bus.mem_wr    = wr_q;
  assign bus.mem_size  = size_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
endmodule

// File: rtl/cpu_sram_like_bridge.sv
// cpu_sram_like_bridge: serialises per-cycle inst/data SRAM accesses onto one SRAM-like bus,
// stalling the core until both complete and presenting read data in a one-cycle release.
module cpu_sram_like_bridge
  import cpu_sram_like_bridge_pkg::*;
#(
  parameter bit DATA_FIRST = 1'b1,
  parameter int ADDR_W     = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              inst_sram_en,
  input  logic [ADDR_W-1:0] inst_sram_addr,
  output logic [31:0]       inst_sram_rdata,
  input  logic              data_sram_en,
  input  logic [3:0]        data_sram_wen,
  input  logic [ADDR_W-1:0] data_sram_addr,
  input  logic [31:0]       data_sram_wdata,
  output logic [31:0]       data_sram_rdata,
  output logic              cpu_stall,
  cpu_sram_like_bridge_if.master bus
);
  state_e            state_q, state_d;
  logic              i_en_q, i_en_d, d_en_q, d_en_d;
  logic [3:0]        d_wen_q, d_wen_d;
  logic [ADDR_W-1:0] i_addr_q, i_addr_d, d_addr_q, d_addr_d;
  logic [31:0]       d_wdata_q, d_wdata_d, i_rdata_q, i_rdata_d, d_rdata_q, d_rdata_d;
  logic              en_any, latch, first_en, second_en, in_req, in_wait, cur_data;
  logic              accepted, done, load, ld_data, ld_wr;
  logic [1:0]        ld_size;
  logic [ADDR_W-1:0] ld_addr;
  logic [31:0]       ld_wdata;
  assign en_any   = inst_sram_en | data_sram_en;
  assign in_req   = state_q == FIRST_REQ || state_q == SECOND_REQ;
  assign in_wait  = state_q == FIRST_WAIT || state_q == SECOND_WAIT;
  assign cur_data = (state_q == FIRST_REQ || state_q == FIRST_WAIT) == DATA_FIRST;
  always_comb begin
    latch     = state_q == IDLE && en_any;
    i_en_d    = latch ? inst_sram_en : i_en_q;
    i_addr_d  = latch ? inst_sram_addr : i_addr_q;
    d_en_d    = latch ? data_sram_en : d_en_q;
    d_wen_d   = latch ? data_sram_wen : d_wen_q;
    d_addr_d  = latch ? data_sram_addr : d_addr_q;
    d_wdata_d = latch ? data_sram_wdata : d_wdata_q;
    first_en  = DATA_FIRST ? d_en_d : i_en_d;
    second_en = DATA_FIRST ? i_en_d : d_en_d;
    state_d   = state_q;
    case (state_q)
      IDLE:                    state_d = en_any ? (first_en ? FIRST_REQ : SECOND_REQ) : IDLE;
      FIRST_REQ, FIRST_WAIT:   state_d = done ? (second_en ? SECOND_REQ : RELEASE) : accepted ? FIRST_WAIT : state_q;
      SECOND_REQ, SECOND_WAIT: state_d = done ? RELEASE : accepted ? SECOND_WAIT : state_q;
      default:                 state_d = IDLE;
    endcase
    // the payload port is reloaded on every entry to a request phase, from the latched (or just-latching) inputs
    load      = state_d != state_q && (state_d == FIRST_REQ || state_d == SECOND_REQ);
    ld_data   = (state_d == FIRST_REQ) == DATA_FIRST;
    ld_wr     = ld_data && |d_wen_d;
    ld_size   = ld_data ? wen_to_size(d_wen_d) : SZ_W;
    ld_addr   = ld_data ? d_addr_d : i_addr_d;
    ld_wdata  = ld_data ? d_wdata_d : 32'd0;
    i_rdata_d = done && !cur_data ? bus.mem_rdata : i_rdata_q;
    d_rdata_d = done && cur_data && d_wen_q == 4'd0 ? bus.mem_rdata : d_rdata_q;
    cpu_stall = resetn && state_q != RELEASE && (state_q != IDLE || en_any);
  end
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q   <= IDLE;
      i_en_q    <= 1'b0;
      i_addr_q  <= '0;
      d_en_q    <= 1'b0;
      d_wen_q   <= 4'd0;
      d_addr_q  <= '0;
      d_wdata_q <= 32'd0;
      i_rdata_q <= 32'd0;
      d_rdata_q <= 32'd0;
    end else begin
      state_q   <= state_d;
      i_en_q    <= i_en_d;
      i_addr_q  <= i_addr_d;
      d_en_q    <= d_en_d;
      d_wen_q   <= d_wen_d;
      d_addr_q  <= d_addr_d;
      d_wdata_q <= d_wdata_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
    end
  end
  assign inst_sram_rdata = i_rdata_q;
  assign data_sram_rdata = d_rdata_q;
  sram_like_req_port #(.ADDR_W(ADDR_W)) u_port (
    .clk      (clk),
    .resetn   (resetn),
    .load     (load),
    .ld_wr    (ld_wr),
    .ld_size  (ld_size),
    .ld_addr  (ld_addr),
    .ld_wdata (ld_wdata),
    .in_req   (in_req),
    .in_wait  (in_wait),
    .accepted (accepted),
    .done     (done),
    .bus      (bus)
  );
endmodule
